// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: element width, default map dims, the
// layer FSM encoding and a signed max helper reused by later layers.
package cnn_pkg;
  localparam int CNN_DATA_W = 32;
  localparam int CNN_IN_DIM = 6;
  localparam int CNN_POOL   = 2;

  // Wide enough to hold any supported element width after sign extension
  localparam int MAX_W = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic signed [MAX_W-1:0] smax(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// Window-major scan counters for the pooling layer: walks win_row, win_col,
// then in-window r, c, and emits the flat read index plus window markers.
module pool_addr_gen import cnn_pkg::*; #(
  parameter  int IN_DIM  = CNN_IN_DIM,
  parameter  int POOL    = CNN_POOL,
  localparam int OUT_DIM = IN_DIM / POOL,
  localparam int IDX_W   = (IN_DIM*IN_DIM > 1) ? $clog2(IN_DIM*IN_DIM) : 1,
  localparam int OIDX_W  = (OUT_DIM*OUT_DIM > 1) ? $clog2(OUT_DIM*OUT_DIM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic [OIDX_W-1:0] out_idx_o,
  output logic              first_in_win_o,
  output logic              last_in_win_o,
  output logic              last_elem_o
);
  localparam int CW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int WW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  logic [CW-1:0] c_q, c_d, r_q, r_d;
  logic [WW-1:0] wc_q, wc_d, wr_q, wr_d;
  logic          c_end, r_end, wc_end, wr_end;

  assign c_end  = (c_q  == CW'(POOL-1));
  assign r_end  = (r_q  == CW'(POOL-1));
  assign wc_end = (wc_q == WW'(OUT_DIM-1));
  assign wr_end = (wr_q == WW'(OUT_DIM-1));

  // Nested odometer; the final element wraps every counter back to 0
  always_comb begin
    c_d  = c_q;
    r_d  = r_q;
    wc_d = wc_q;
    wr_d = wr_q;
    if (en_i) begin
      c_d = c_end ? '0 : c_q + 1'b1;
      if (c_end) begin
        r_d = r_end ? '0 : r_q + 1'b1;
        if (r_end) begin
          wc_d = wc_end ? '0 : wc_q + 1'b1;
          if (wc_end) wr_d = wr_end ? '0 : wr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q  <= '0;
      r_q  <= '0;
      wc_q <= '0;
      wr_q <= '0;
    end else begin
      c_q  <= c_d;
      r_q  <= r_d;
      wc_q <= wc_d;
      wr_q <= wr_d;
    end
  end

  assign rd_idx_o  = IDX_W'((int'(wr_q)*POOL + int'(r_q))*IN_DIM + int'(wc_q)*POOL + int'(c_q));
  assign out_idx_o = OIDX_W'(int'(wr_q)*OUT_DIM + int'(wc_q));

  assign first_in_win_o = (r_q == '0) && (c_q == '0);
  assign last_in_win_o  = c_end && r_end;
  assign last_elem_o    = c_end && r_end && wc_end && wr_end;
endmodule

// File: rtl/maxpool_engine.sv
// Layer-2 max-pool responder: one element per cycle, done pulse on completion.
// Define MAXPOOL_RELU_EN to clamp negative window maxima to 0 (fused ReLU).
module maxpool_engine import cnn_pkg::*; #(
  parameter  int DATA_W  = CNN_DATA_W,
  parameter  int IN_DIM  = CNN_IN_DIM,
  parameter  int POOL    = CNN_POOL,
  localparam int OUT_DIM = IN_DIM / POOL,
  localparam int IN_N    = IN_DIM * IN_DIM,
  localparam int OUT_N   = OUT_DIM * OUT_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W*IN_N-1:0]  input_fm,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W*OUT_N-1:0] output_fm
);
  localparam int IDX_W  = (IN_N  > 1) ? $clog2(IN_N)  : 1;
  localparam int OIDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic [1:0]                    state_q, state_d;
  logic signed [DATA_W-1:0]      acc_q, acc_d;
  logic [OUT_N-1:0][DATA_W-1:0]  out_q, out_d;
  logic [IN_N-1:0][DATA_W-1:0]   in_arr;

  logic [IDX_W-1:0]         rd_idx;
  logic [OIDX_W-1:0]        out_idx;
  logic                     first_in_win, last_in_win, last_elem, scan;
  logic signed [DATA_W-1:0] elem, mx, win_val, wr_val;

  assign scan = (state_q == ST_SCAN);

  pool_addr_gen #(.IN_DIM(IN_DIM), .POOL(POOL)) u_addr (
    .clk           (clk),
    .rst           (rst),
    .en_i          (scan),
    .rd_idx_o      (rd_idx),
    .out_idx_o     (out_idx),
    .first_in_win_o(first_in_win),
    .last_in_win_o (last_in_win),
    .last_elem_o   (last_elem)
  );

  assign in_arr = input_fm;
  assign elem   = $signed(in_arr[rd_idx]);
  assign mx     = DATA_W'(smax(MAX_W'(acc_q), MAX_W'(elem)));
  // Window's first element stands alone; no -inf seed needed
  assign win_val = first_in_win ? elem : mx;

`ifdef MAXPOOL_RELU_EN
  assign wr_val = win_val[DATA_W-1] ? '0 : win_val;
`else
  assign wr_val = win_val;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (last_elem) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (scan) begin
      acc_d = win_val;
      if (last_in_win) out_d[out_idx] = wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign output_fm = out_q;
endmodule

// File: tb/tb_maxpool_engine.sv
// Directed bench for maxpool_engine: table of input maps with hand-computed
// pooled results, plus re-pulse, mid-scan reset and back-to-back sequences.
module tb_maxpool_engine;
  localparam int DW    = 32;
  localparam int IN_N  = 36;
  localparam int OUT_N = 9;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [DW*IN_N-1:0]    input_fm = '0;
  logic                  busy, done;
  logic [DW*OUT_N-1:0]   output_fm;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  maxpool_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .input_fm (input_fm),
    .busy     (busy),
    .done     (done),
    .output_fm(output_fm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string               name;
    logic [DW*IN_N-1:0]  fm;
    logic [DW*OUT_N-1:0] exp;
  } vec_t;

  vec_t vecs[4];

  int e_ramp[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
  int e_neg[9]  = '{-5, -7, -9, -17, -19, -21, -29, -31, -33};
  int e_rev[9]  = '{35, 33, 31, 23, 21, 19, 11, 9, 7};

  logic [DW*IN_N-1:0]  fm_ramp, fm_neg, fm_rev, fm_x;
  logic [DW*OUT_N-1:0] ex_ramp, ex_neg, ex_rev, ex_x;

  int fd, nd, d1, d2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [DW*OUT_N-1:0] exp);
    for (int j = 0; j < OUT_N; j++)
      chk($sformatf("%s out[%0d]", tag, j), 64'(output_fm[j*DW +: DW]), 64'(exp[j*DW +: DW]));
  endtask

  // Pulse start, optionally re-pulse at cycles p1/p2, observe 80 cycles
  task automatic run_scan(input logic [DW*IN_N-1:0] fm, input int p1, input int p2,
                          output int first_done, output int ndone);
    @(negedge clk);
    input_fm = fm;
    start    = 1'b1;
    first_done = -1;
    ndone      = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k == p1) || (k == p2);
      if (done) begin
        if (ndone == 0) first_done = k;
        ndone++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < IN_N; i++) begin
      fm_ramp[i*DW +: DW] = 32'(i);
      fm_neg[i*DW +: DW]  = 32'(-5 - i);
      fm_rev[i*DW +: DW]  = 32'(35 - i);
    end
    fm_x = '0;
    fm_x[0*DW +: DW] = 32'h8000_0000;
    fm_x[1*DW +: DW] = 32'h8000_0000;
    fm_x[6*DW +: DW] = 32'h8000_0000;
    fm_x[7*DW +: DW] = 32'h7FFF_FFFF;
    fm_x[2*DW +: DW] = 32'h8000_0000;
    fm_x[3*DW +: DW] = 32'h8000_0000;
    fm_x[8*DW +: DW] = 32'h8000_0000;
    fm_x[9*DW +: DW] = 32'h8000_0000;

    ex_x = '0;
    ex_x[0*DW +: DW] = 32'h7FFF_FFFF;
    for (int j = 0; j < OUT_N; j++) begin
      ex_ramp[j*DW +: DW] = 32'(e_ramp[j]);
      ex_rev[j*DW +: DW]  = 32'(e_rev[j]);
`ifdef MAXPOOL_RELU_EN
      ex_neg[j*DW +: DW]  = 32'(0);
`else
      ex_neg[j*DW +: DW]  = 32'(e_neg[j]);
`endif
    end
`ifndef MAXPOOL_RELU_EN
    ex_x[1*DW +: DW] = 32'h8000_0000;
`endif

    vecs[0] = '{name: "ramp",     fm: fm_ramp, exp: ex_ramp};
    vecs[1] = '{name: "negative", fm: fm_neg,  exp: ex_neg};
    vecs[2] = '{name: "extremes", fm: fm_x,    exp: ex_x};
    vecs[3] = '{name: "reversed", fm: fm_rev,  exp: ex_rev};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset out nonzero", 64'(|output_fm), 64'(0));
    rst = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_scan(vecs[v].fm, 0, 0, fd, nd);
      chk({vecs[v].name, " latency"}, 64'(fd), 64'(37));
      chk({vecs[v].name, " done count"}, 64'(nd), 64'(1));
      chk_out(vecs[v].name, vecs[v].exp);
    end

    // start re-pulsed while busy must be ignored
    run_scan(fm_ramp, 10, 20, fd, nd);
    chk("repulse latency", 64'(fd), 64'(37));
    chk("repulse done count", 64'(nd), 64'(1));
    chk_out("repulse", ex_ramp);

    // reset mid-scan clears everything asynchronously
    @(negedge clk);
    input_fm = fm_ramp;
    start    = 1'b1;
    repeat (15) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midscan busy before rst", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    chk("midscan rst busy", 64'(busy), 64'(0));
    chk("midscan rst done", 64'(done), 64'(0));
    chk("midscan rst out nonzero", 64'(|output_fm), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    run_scan(fm_ramp, 0, 0, fd, nd);
    chk("post-rst latency", 64'(fd), 64'(37));
    chk("post-rst done count", 64'(nd), 64'(1));
    chk_out("post-rst", ex_ramp);

    // back-to-back: new start in the cycle right after done
    d1 = -1;
    d2 = -1;
    @(negedge clk);
    input_fm = fm_ramp;
    start    = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        d1 = cyc;
        break;
      end
    end
    chk("b2b first done seen", 64'(d1 >= 0), 64'(1));
    @(negedge clk);
    input_fm = fm_rev;
    start    = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        d2 = cyc;
        break;
      end
    end
    chk("b2b done gap", 64'(d2 - d1), 64'(38));
    chk_out("b2b", ex_rev);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
